// File: rtl/save_loader.sv
// Bridge-to-cartridge save loader: buffers 32-bit bridge writes in a small FIFO and
// commits each word as four timed byte writes into the cartridge SRAM through the MBC.
//
// Bridge handshake: there is no ready. A word is taken on every cycle with
// bridge_wr=1 while the FIFO has room (a pop in the same cycle makes room). A word
// that arrives while the FIFO is full is dropped and sets the sticky overflow flag.
module save_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  WR_CYCLES  = 8'h3F,
  parameter logic [15:0] SRAM_BASE  = 16'hA000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_addr,
  input  logic [31:0] bridge_wr_data,
  output logic        busy,
  output logic        overflow,
  output logic [23:0] bytes_written,
  output logic [15:0] cart_address,
  output logic [3:0]  cart_tran_bank0_out,
  output logic [7:0]  cart_tran_bank1_out,
  output logic        cart_tran_bank1_dir,
  output logic [2:0]  dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 15 + 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RAM_EN  = 3'd1,
    S_BANK    = 3'd2,
    S_WRITE   = 3'd3,
    S_DELAY   = 3'd4,
    S_RELEASE = 3'd5,
    S_NEXT    = 3'd6
  } state_t;

  // With no extra hold cycles the write state itself is the whole pulse.
  localparam state_t HOLD_NEXT = (WR_CYCLES == 8'd0) ? S_RELEASE : S_DELAY;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;

  // Cart FSM state
  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ram_en_done_q, ram_en_done_d;
  logic        bank_valid_q, bank_valid_d;
  logic [7:0]  cur_bank_q, cur_bank_d;
  logic [23:0] bytes_q, bytes_d;

  // Registered cart bus
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wr_q, wr_d;
  logic        dir_q, dir_d;

  logic [ENT_W-1:0] head;
  logic [14:0]      head_word_addr;
  logic [31:0]      head_data;
  logic [7:0]       head_bank;
  logic             bank_change;
  logic [12:0]      byte_offset;
  logic [7:0]       byte_data;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{bridge_addr[31:17], bridge_addr[1:0]};

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign head           = mem_q[rd_ptr_q];
  assign head_word_addr = head[46:32];
  assign head_data      = head[31:0];
  // Word address bit i is byte address bit i+2, so [14:11] is the 8 KiB bank.
  assign head_bank      = {4'h0, head_word_addr[14:11]};
  assign bank_change    = !bank_valid_q || (head_bank != cur_bank_q);

  always_comb begin
    push       = bridge_wr && (!fifo_full || pop);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q | (bridge_wr & fifo_full & ~pop);
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bridge_addr[16:2], bridge_wr_data};
    end
  end

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    k_d           = k_q;
    cnt_d         = cnt_q;
    ram_en_done_d = ram_en_done_q;
    bank_valid_d  = bank_valid_q;
    cur_bank_d    = cur_bank_q;
    bytes_d       = bytes_q;
    pop           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (!ram_en_done_q)   state_d = S_RAM_EN;
          else if (bank_change) state_d = S_BANK;
          else                  state_d = S_WRITE;
        end
      end
      S_RAM_EN: begin
        ram_en_done_d = 1'b1;
        ret_d         = S_BANK;
        cnt_d         = WR_CYCLES;
        state_d       = HOLD_NEXT;
      end
      S_BANK: begin
        cur_bank_d   = head_bank;
        bank_valid_d = 1'b1;
        ret_d        = S_WRITE;
        cnt_d        = WR_CYCLES;
        state_d      = HOLD_NEXT;
      end
      S_WRITE: begin
        ret_d   = S_NEXT;
        cnt_d   = WR_CYCLES;
        state_d = HOLD_NEXT;
      end
      S_DELAY: begin
        // The write-state cycle already counts as the first cycle of the pulse.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = ret_q;
      end
      S_NEXT: begin
        bytes_d = bytes_q + 24'd1;
        if (k_q == 2'd3) begin
          pop     = 1'b1;
          k_d     = 2'd0;
          state_d = S_IDLE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = bank_change ? S_BANK : S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_offset = {head_word_addr[10:0], k_d};
    case (k_d)
      2'd0:    byte_data = head_data[31:24];
      2'd1:    byte_data = head_data[23:16];
      2'd2:    byte_data = head_data[15:8];
      default: byte_data = head_data[7:0];
    endcase

    // Bus values are launched from the next state so wr, address and data rise together.
    addr_d = addr_q;
    data_d = data_q;
    wr_d   = wr_q;
    dir_d  = dir_q;
    case (state_d)
      S_RAM_EN: begin
        addr_d = 16'h0000;
        data_d = 8'h0A;
        wr_d   = 1'b1;
        dir_d  = 1'b1;
      end
      S_BANK: begin
        addr_d = 16'h4000;
        data_d = head_bank;
        wr_d   = 1'b1;
        dir_d  = 1'b1;
      end
      S_WRITE: begin
        addr_d = SRAM_BASE + {3'b000, byte_offset};
        data_d = byte_data;
        wr_d   = 1'b1;
        dir_d  = 1'b1;
      end
      S_DELAY: begin
      end
      default: begin
        wr_d  = 1'b0;
        dir_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      state_q       <= S_IDLE;
      ret_q         <= S_IDLE;
      k_q           <= 2'd0;
      cnt_q         <= 8'd0;
      ram_en_done_q <= 1'b0;
      bank_valid_q  <= 1'b0;
      cur_bank_q    <= 8'd0;
      bytes_q       <= 24'd0;
      addr_q        <= 16'h0000;
      data_q        <= 8'h00;
      wr_q          <= 1'b0;
      dir_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
      ret_q         <= ret_d;
      k_q           <= k_d;
      cnt_q         <= cnt_d;
      ram_en_done_q <= ram_en_done_d;
      bank_valid_q  <= bank_valid_d;
      cur_bank_q    <= cur_bank_d;
      bytes_q       <= bytes_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wr_q          <= wr_d;
      dir_q         <= dir_d;
    end
  end

  assign busy                = !fifo_empty || (state_q != S_IDLE);
  assign overflow            = overflow_q;
  assign bytes_written       = bytes_q;
  assign cart_address        = addr_q;
  assign cart_tran_bank0_out = {1'b0, ~wr_q, 1'b1, wr_q};
  assign cart_tran_bank1_out = data_q;
  assign cart_tran_bank1_dir = dir_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_save_loader.sv
// Directed bench for save_loader: expected cart bus writes are queued as words are sent,
// and a bus monitor pops and compares every write plus its WR pulse timing.
module tb_save_loader;

  localparam logic [7:0] WR_CYCLES = 8'h3F;
  localparam logic [2:0] ST_DELAY  = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd6;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        bridge_wr;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_wr_data;
  logic        busy;
  logic        overflow;
  logic [23:0] bytes_written;
  logic [15:0] cart_address;
  logic [3:0]  cart_tran_bank0_out;
  logic [7:0]  cart_tran_bank1_out;
  logic        cart_tran_bank1_dir;
  logic [2:0]  dbg_state;
  logic        cart_wr;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q[$];

  save_loader #(
    .FIFO_DEPTH(4),
    .WR_CYCLES (WR_CYCLES),
    .SRAM_BASE (16'hA000)
  ) dut (
    .clk_sys            (clk_sys),
    .reset              (reset),
    .bridge_wr          (bridge_wr),
    .bridge_addr        (bridge_addr),
    .bridge_wr_data     (bridge_wr_data),
    .busy               (busy),
    .overflow           (overflow),
    .bytes_written      (bytes_written),
    .cart_address       (cart_address),
    .cart_tran_bank0_out(cart_tran_bank0_out),
    .cart_tran_bank1_out(cart_tran_bank1_out),
    .cart_tran_bank1_dir(cart_tran_bank1_dir),
    .dbg_state          (dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;
  assign cart_wr = cart_tran_bank0_out[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  logic        prev_wr = 1'b0;
  int          hold = 0;
  logic [15:0] cur_a;
  logic [7:0]  cur_d;
  logic [23:0] exp_w;

  always @(negedge clk_sys) begin
    if (reset) begin
      prev_wr = 1'b0;
      hold    = 0;
    end else begin
      check("bank0_fixed_bits", {29'd0, cart_tran_bank0_out[3:1]}, {29'd0, 1'b0, ~cart_wr, 1'b1});
      check("dir_eq_wr", {31'd0, cart_tran_bank1_dir}, {31'd0, cart_wr});
      if (cart_wr && !prev_wr) begin
        cur_a = cart_address;
        cur_d = cart_tran_bank1_out;
        hold  = 1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %h:%h want none", cur_a, cur_d);
        end else begin
          exp_w = exp_q.pop_front();
          check("bus_write", {8'd0, cur_a, cur_d}, {8'd0, exp_w});
        end
      end else if (cart_wr) begin
        hold++;
        check("hold_stable", {8'd0, cart_address, cart_tran_bank1_out}, {8'd0, cur_a, cur_d});
      end else if (prev_wr) begin
        check("wr_hold_len", hold, 32'(WR_CYCLES) + 32'd1);
      end
      prev_wr = cart_wr;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d);
    bridge_wr      = 1'b1;
    bridge_addr    = a;
    bridge_wr_data = d;
    tick();
    bridge_wr      = 1'b0;
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic exp_word(input logic [31:0] a, input logic [31:0] d,
                          input bit ram_en, input bit bank_wr);
    if (ram_en)  exp_write(16'h0000, 8'h0A);
    if (bank_wr) exp_write(16'h4000, {4'h0, a[16:13]});
    for (int k = 0; k < 4; k++) begin
      exp_write(16'hA000 + {3'b000, a[12:2], k[1:0]}, d[31-8*k -: 8]);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 4000) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_state(input logic [2:0] st, input logic [23:0] bw, input string name);
    int n = 0;
    while (!(dbg_state == st && bytes_written == bw) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      total++;
      bad++;
      $display("FAIL %s: got state %0d bytes %0d want state %0d bytes %0d",
               name, dbg_state, bytes_written, st, bw);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bridge_wr      = 1'b0;
    bridge_addr    = 32'd0;
    bridge_wr_data = 32'd0;
    repeat (4) tick();

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_bytes", {8'd0, bytes_written}, 32'd0);
    check("rst_addr", {16'd0, cart_address}, 32'd0);
    check("rst_bank0", {28'd0, cart_tran_bank0_out}, 32'h6);
    check("rst_bank1", {24'd0, cart_tran_bank1_out}, 32'd0);
    check("rst_dir", {31'd0, cart_tran_bank1_dir}, 32'd0);
    reset = 1'b0;
    tick();

    // single word: RAM enable, bank 0, four bytes
    exp_word(32'h0000_0000, 32'h1122_3344, 1'b1, 1'b1);
    send(32'h0000_0000, 32'h1122_3344);
    wait_idle("t1_idle");
    check("t1_bytes", {8'd0, bytes_written}, 32'd4);
    check("t1_queue_empty", exp_q.size(), 32'd0);

    // top of bank 0 then start of bank 1
    exp_word(32'h0000_1FFC, 32'hAABB_CCDD, 1'b0, 1'b0);
    exp_word(32'h0000_2000, 32'h0102_0304, 1'b0, 1'b1);
    send(32'h0000_1FFC, 32'hAABB_CCDD);
    send(32'h0000_2000, 32'h0102_0304);
    wait_idle("t2_idle");
    check("t2_bytes", {8'd0, bytes_written}, 32'd12);
    check("t2_queue_empty", exp_q.size(), 32'd0);

    // six back-to-back words: four kept, two dropped
    exp_word(32'h0000_4000, 32'hC0C1_C2C3, 1'b0, 1'b1);
    exp_word(32'h0000_4004, 32'hD0D1_D2D3, 1'b0, 1'b0);
    exp_word(32'h0000_4008, 32'hE0E1_E2E3, 1'b0, 1'b0);
    exp_word(32'h0000_400C, 32'hF0F1_F2F3, 1'b0, 1'b0);
    send(32'h0000_4000, 32'hC0C1_C2C3);
    send(32'h0000_4004, 32'hD0D1_D2D3);
    send(32'h0000_4008, 32'hE0E1_E2E3);
    send(32'h0000_400C, 32'hF0F1_F2F3);
    check("t3_no_ovf_yet", {31'd0, overflow}, 32'd0);
    send(32'h0000_4010, 32'h1234_5678);
    send(32'h0000_4014, 32'h9ABC_DEF0);
    check("t3_overflow_set", {31'd0, overflow}, 32'd1);
    wait_idle("t3_idle");
    check("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
    check("t3_bytes", {8'd0, bytes_written}, 32'd28);
    check("t3_queue_empty", exp_q.size(), 32'd0);

    // reset during the hold of byte 2
    exp_write(16'h4000, 8'h03);
    exp_write(16'hA000, 8'h55);
    exp_write(16'hA001, 8'h66);
    exp_write(16'hA002, 8'h77);
    send(32'h0000_6000, 32'h5566_7788);
    wait_state(ST_DELAY, 24'd30, "t5_reach_byte2");
    reset = 1'b1;
    tick();
    check("t5_wr_low", {31'd0, cart_wr}, 32'd0);
    check("t5_dir_low", {31'd0, cart_tran_bank1_dir}, 32'd0);
    check("t5_busy_low", {31'd0, busy}, 32'd0);
    check("t5_overflow_clr", {31'd0, overflow}, 32'd0);
    check("t5_bytes_clr", {8'd0, bytes_written}, 32'd0);
    reset = 1'b0;
    tick();
    check("t5_queue_empty", exp_q.size(), 32'd0);

    // fill the FIFO, then write in the same cycle as the first pop
    exp_word(32'h0000_0010, 32'h0123_4567, 1'b1, 1'b1);
    exp_word(32'h0000_0014, 32'h89AB_CDEF, 1'b0, 1'b0);
    exp_word(32'h0000_0018, 32'h0F1E_2D3C, 1'b0, 1'b0);
    exp_word(32'h0000_001C, 32'h4B5A_6978, 1'b0, 1'b0);
    exp_word(32'h0000_0020, 32'hC3D2_E1F0, 1'b0, 1'b0);
    send(32'h0000_0010, 32'h0123_4567);
    send(32'h0000_0014, 32'h89AB_CDEF);
    send(32'h0000_0018, 32'h0F1E_2D3C);
    send(32'h0000_001C, 32'h4B5A_6978);
    wait_state(ST_NEXT, 24'd3, "t6_reach_pop");
    send(32'h0000_0020, 32'hC3D2_E1F0);
    check("t6_no_overflow", {31'd0, overflow}, 32'd0);
    wait_idle("t6_idle");
    check("t6_overflow_final", {31'd0, overflow}, 32'd0);
    check("t6_bytes", {8'd0, bytes_written}, 32'd20);
    check("t6_queue_empty", exp_q.size(), 32'd0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
